// File: rtl/fp_pkg.sv
// Shared single-precision types and constants for the FP normalizer.
// Holds the FSM state enum and the packed IEEE-754 field layout.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 24;
  localparam int FP_FRAC_W = FP_MANT_W - 1;

  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic [31:0] fp_pack(
    input logic                 s,
    input logic [FP_EXP_W-1:0]  e,
    input logic [FP_FRAC_W-1:0] f
  );
    fp32_t r;
    r.sign = s;
    r.exp  = e;
    r.frac = f;
    return r;
  endfunction

endpackage

// File: rtl/fp_round_unit.sv
// Round-to-nearest-even on a normalized 24-bit mantissa.
// Purely combinational; flags exponent saturation after a carry-out.
module fp_round_unit
  import fp_pkg::*;
(
  input  logic [FP_MANT_W-1:0] mant,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic [FP_EXP_W:0]    exp,
  output logic [FP_MANT_W-1:0] rnd_mant,
  output logic [FP_EXP_W:0]    rnd_exp,
  output logic                 rnd_ovf
);

  logic             up;
  logic [FP_MANT_W:0] sum;

  assign up  = guard & (sticky | mant[0]);
  assign sum = {1'b0, mant} + {{FP_MANT_W{1'b0}}, up};

  always_comb begin
    rnd_mant = sum[FP_MANT_W-1:0];
    rnd_exp  = exp;
    if (sum[FP_MANT_W]) begin
      rnd_mant = 24'h800000;
      rnd_exp  = exp + 9'd1;
    end
  end

  assign rnd_ovf = rnd_exp >= {1'b0, FP_EXP_MAX};

endmodule

// File: rtl/fp_normalizer.sv
// Post-ALU normalize/round stage; iterative 1-bit shifts, valid/ready both sides.
// FP_ROUND_NEAREST_EN enables round-to-nearest-even, otherwise truncates.
module fp_normalizer
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [FP_EXP_W-1:0]  in_exp,
  input  logic                 in_carry,
  input  logic [FP_MANT_W-1:0] in_mant,
  input  logic                 in_guard,
  input  logic                 in_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_overflow,
  output logic                 out_underflow
);

  state_t               state;
  logic                 sign;
  logic [FP_EXP_W:0]    exp;
  logic [FP_MANT_W-1:0] mant;
  logic                 guard;
  logic                 exp_max;
  logic                 exp_low;

  assign in_ready = (state == IDLE);
  assign exp_max  = exp >= {1'b0, FP_EXP_MAX};
  assign exp_low  = exp <= 9'd1;

`ifdef FP_ROUND_NEAREST_EN
  logic                 sticky;
  logic [FP_MANT_W-1:0] rnd_mant;
  logic [FP_EXP_W:0]    rnd_exp;
  logic                 rnd_ovf;

  fp_round_unit u_round (
    .mant     (mant),
    .guard    (guard),
    .sticky   (sticky),
    .exp      (exp),
    .rnd_mant (rnd_mant),
    .rnd_exp  (rnd_exp),
    .rnd_ovf  (rnd_ovf)
  );
`else
  logic unused_sticky;
  assign unused_sticky = in_sticky;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sign          <= 1'b0;
      exp           <= '0;
      mant          <= '0;
      guard         <= 1'b0;
`ifdef FP_ROUND_NEAREST_EN
      sticky        <= 1'b0;
`endif
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= in_sign;
            state <= SHIFT;
            if (in_carry) begin
              mant  <= {1'b1, in_mant[FP_MANT_W-1:1]};
              guard <= in_mant[0];
              exp   <= {1'b0, in_exp} + 9'd1;
`ifdef FP_ROUND_NEAREST_EN
              sticky <= in_guard | in_sticky;
`endif
            end else begin
              mant  <= in_mant;
              guard <= in_guard;
              exp   <= {1'b0, in_exp};
`ifdef FP_ROUND_NEAREST_EN
              sticky <= in_sticky;
`endif
            end
          end
        end
        SHIFT: begin
          if (exp_max) begin
            out_result    <= fp_pack(sign, FP_EXP_MAX, '0);
            out_overflow  <= 1'b1;
            out_underflow <= 1'b0;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else if (mant == '0) begin
            out_result    <= fp_pack(sign, '0, '0);
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else if (mant[FP_MANT_W-1]) begin
`ifdef FP_ROUND_NEAREST_EN
            state         <= ROUND;
`else
            out_result    <= fp_pack(sign, exp[FP_EXP_W-1:0],
                                     mant[FP_FRAC_W-1:0]);
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_valid     <= 1'b1;
            state         <= DONE;
`endif
          end else if (exp_low) begin
            // no denormals: anything that would need one flushes to zero
            out_result    <= fp_pack(sign, '0, '0);
            out_overflow  <= 1'b0;
            out_underflow <= 1'b1;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            mant  <= {mant[FP_MANT_W-2:0], guard};
            guard <= 1'b0;
            exp   <= exp - 9'd1;
          end
        end
`ifdef FP_ROUND_NEAREST_EN
        ROUND: begin
          if (rnd_ovf) begin
            out_result    <= fp_pack(sign, FP_EXP_MAX, '0);
            out_overflow  <= 1'b1;
          end else begin
            out_result    <= fp_pack(sign, rnd_exp[FP_EXP_W-1:0],
                                     rnd_mant[FP_FRAC_W-1:0]);
            out_overflow  <= 1'b0;
          end
          out_underflow <= 1'b0;
          out_valid     <= 1'b1;
          state         <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer.
// Expectations follow FP_ROUND_NEAREST_EN when it is defined for the build.
module tb_fp_normalizer;

`ifdef FP_ROUND_NEAREST_EN
  localparam int RL = 3;
  localparam logic [31:0] RND_RES = 32'h40000000;
`else
  localparam int RL = 2;
  localparam logic [31:0] RND_RES = 32'h3FFFFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_carry;
  logic [23:0] in_mant;
  logic        in_guard;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_normalizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_carry      (in_carry),
    .in_mant       (in_mant),
    .in_guard      (in_guard),
    .in_sticky     (in_sticky),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one bundle; returns #1 after the accepting edge.
  task automatic issue(input logic s, input logic [7:0] e,
                       input logic c, input logic [23:0] m,
                       input logic g, input logic st);
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_carry  = c;
    in_mant   = m;
    in_guard  = g;
    in_sticky = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Accepting edge counts as cycle 1.
  task automatic wait_done(input string tag, input int lat_exp,
                           input logic [31:0] res, input logic ov,
                           input logic un);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_res"}, out_result, res);
    chk({tag, "_ovf"}, 32'(out_overflow), 32'(ov));
    chk({tag, "_unf"}, 32'(out_underflow), 32'(un));
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_carry  = 1'b0;
    in_mant   = '0;
    in_guard  = 1'b0;
    in_sticky = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_res", out_result, 32'h0);
    chk("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 8'h7F, 1'b1, 24'h000000, 1'b0, 1'b0);
    wait_done("carry", RL, 32'h40000000, 1'b0, 1'b0);
    handshake("carry");

    issue(1'b0, 8'h7F, 1'b0, 24'h000001, 1'b0, 1'b0);
    wait_done("maxshift", RL + 23, 32'h34000000, 1'b0, 1'b0);
    handshake("maxshift");

    issue(1'b1, 8'h7F, 1'b0, 24'h000000, 1'b0, 1'b0);
    wait_done("zero", 2, 32'h80000000, 1'b0, 1'b0);
    handshake("zero");

    issue(1'b0, 8'hFE, 1'b1, 24'h000000, 1'b0, 1'b0);
    wait_done("ovf", 2, 32'h7F800000, 1'b1, 1'b0);
    handshake("ovf");

    issue(1'b0, 8'h05, 1'b0, 24'h000001, 1'b0, 1'b0);
    wait_done("unf", 6, 32'h00000000, 1'b0, 1'b1);
    handshake("unf");

    issue(1'b0, 8'h7F, 1'b0, 24'hFFFFFF, 1'b1, 1'b1);
    wait_done("round", RL, RND_RES, 1'b0, 1'b0);
    handshake("round");

    issue(1'b0, 8'h7F, 1'b1, 24'h000000, 1'b0, 1'b0);
    wait_done("bp", RL, 32'h40000000, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_mant  = 24'h000000;
    in_carry = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_res", out_result, 32'h40000000);
      chk("bp_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    @(posedge clk);
    #1;
    chk("bp_idle", 32'(in_ready), 32'd1);

    issue(1'b0, 8'h7F, 1'b0, 24'h000001, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 8'h7F, 1'b0, 24'h800000, 1'b0, 1'b0);
    wait_done("fresh", RL, 32'h3F800000, 1'b0, 1'b0);
    handshake("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
